// File: rtl/move_special_sequencer.sv
// move_special_sequencer: hardwired fetch + HI/LO move control-step FSM (T0,T1,TW..,T2,T3).
// Latency: 4+max(MEM_WAIT,1) cycles T0..T3 inclusive; IDLE->T0 in 1 cycle; no bubble between instructions.
// Backpressure: none; run is sampled only in IDLE and T3, clr aborts at any point.
//
// Ports:
//   clk, clr          - rising-edge clock, synchronous active-high reset
//   run               - level; keep fetching/executing while high
//   IR                - instruction register, opcode in IR[31 -: OPC_W]
//   PCout..Zlowout    - fetch controls
//   MDRRead..IRin     - memory / IR controls
//   Gra, Rin_in, Rout_in, HIout, LOout, HIin, LOin - execute controls
//   done, illegal     - one-cycle pulses in T3
//   halted            - high in HALTED
//   step              - state encoding for debug
//   instr_count       - retired instruction count (wraps)
module move_special_sequencer #(
  parameter int OPC_W    = 5,
  parameter int MEM_WAIT = 1,
  parameter int CNT_W    = 16,
  parameter logic [OPC_W-1:0] OP_MTHI = 5'd23,
  parameter logic [OPC_W-1:0] OP_MTLO = 5'd24,
  parameter logic [OPC_W-1:0] OP_MFHI = 5'd25,
  parameter logic [OPC_W-1:0] OP_MFLO = 5'd26,
  parameter logic [OPC_W-1:0] OP_NOP  = 5'd27,
  parameter logic [OPC_W-1:0] OP_HALT = 5'd28
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             run,
  input  logic [31:0]      IR,
  output logic             PCout,
  output logic             MARin,
  output logic             IncPC,
  output logic             Zin,
  output logic             PCin,
  output logic             Zlowout,
  output logic             MDRRead,
  output logic             MDRin,
  output logic             MDRout,
  output logic             IRin,
  output logic             Gra,
  output logic             Rin_in,
  output logic             Rout_in,
  output logic             HIout,
  output logic             LOout,
  output logic             HIin,
  output logic             LOin,
  output logic             done,
  output logic             illegal,
  output logic             halted,
  output logic [2:0]       step,
  output logic [CNT_W-1:0] instr_count
);

  // A wait of 0 behaves as 1; the counter is 4 bits so cap at 15.
  localparam int WAIT_EFF = (MEM_WAIT < 1) ? 1 : ((MEM_WAIT > 15) ? 15 : MEM_WAIT);
  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_EFF - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_T0     = 3'd1,
    S_T1     = 3'd2,
    S_TW     = 3'd3,
    S_T2     = 3'd4,
    S_T3     = 3'd5,
    S_HALTED = 3'd6
  } state_t;

  state_t           state;
  logic [3:0]       wait_cnt;
  logic [CNT_W-1:0] count;
  logic [OPC_W-1:0] opc;
  logic             unused_ir;

  assign opc       = IR[31 -: OPC_W];
  assign unused_ir = ^IR[31-OPC_W:0];

  always_ff @(posedge clk) begin
    if (clr) begin
      state    <= S_IDLE;
      wait_cnt <= '0;
      count    <= '0;
    end else begin
      case (state)
        S_IDLE: if (run) state <= S_T0;
        S_T0:   state <= S_T1;
        S_T1: begin
          wait_cnt <= WAIT_LOAD;
          state    <= S_TW;
        end
        S_TW: begin
          if (wait_cnt == 4'd0) state <= S_T2;
          else                  wait_cnt <= wait_cnt - 4'd1;
        end
        S_T2:   state <= S_T3;
        S_T3: begin
          // Illegal opcodes retire too.
          count <= count + CNT_W'(1);
          if (opc == OP_HALT) state <= S_HALTED;
          else if (run)       state <= S_T0;
          else                state <= S_IDLE;
        end
        S_HALTED: state <= S_HALTED;
        default:  state <= S_IDLE;
      endcase
    end
  end

  // Controls decode from the state register; only T3 also looks at IR,
  // which was captured at the end of T2 and is stable here.
  always_comb begin
    PCout = 1'b0; MARin = 1'b0; IncPC = 1'b0; Zin = 1'b0;
    PCin = 1'b0; Zlowout = 1'b0;
    MDRRead = 1'b0; MDRin = 1'b0; MDRout = 1'b0; IRin = 1'b0;
    Gra = 1'b0; Rin_in = 1'b0; Rout_in = 1'b0;
    HIout = 1'b0; LOout = 1'b0; HIin = 1'b0; LOin = 1'b0;
    done = 1'b0; illegal = 1'b0; halted = 1'b0;
    case (state)
      S_T0: begin PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1; end
      S_T1: begin Zlowout = 1'b1; PCin = 1'b1; end
      S_TW: begin
        MDRRead = 1'b1;
        MDRin   = (wait_cnt == 4'd0);
      end
      S_T2: begin MDRout = 1'b1; IRin = 1'b1; end
      S_T3: begin
        done = 1'b1;
        if (opc == OP_MFHI)      begin Gra = 1'b1; Rin_in  = 1'b1; HIout = 1'b1; end
        else if (opc == OP_MFLO) begin Gra = 1'b1; Rin_in  = 1'b1; LOout = 1'b1; end
        else if (opc == OP_MTHI) begin Gra = 1'b1; Rout_in = 1'b1; HIin  = 1'b1; end
        else if (opc == OP_MTLO) begin Gra = 1'b1; Rout_in = 1'b1; LOin  = 1'b1; end
        else if (opc != OP_NOP && opc != OP_HALT) illegal = 1'b1;
      end
      S_HALTED: halted = 1'b1;
      default: ;
    endcase
  end

  assign step        = state;
  assign instr_count = count;

endmodule

// File: tb/tb_move_special_sequencer.sv
module tb_move_special_sequencer;

  localparam int NC = 20;
  localparam int B_PCOUT = 19, B_MARIN = 18, B_INCPC = 17, B_ZIN = 16, B_PCIN = 15;
  localparam int B_ZLOWOUT = 14, B_MDRREAD = 13, B_MDRIN = 12, B_MDROUT = 11, B_IRIN = 10;
  localparam int B_GRA = 9, B_RININ = 8, B_ROUTIN = 7, B_HIOUT = 6, B_LOOUT = 5;
  localparam int B_HIIN = 4, B_LOIN = 3, B_DONE = 2, B_ILL = 1, B_HALTED = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        clr [2];
  logic        run [2];
  logic [31:0] ir  [2];

  wire [NC-1:0] ctl_a, ctl_b;
  wire [2:0]    stp_a, stp_b;
  wire [15:0]   cnt_a;
  wire [1:0]    cnt_b;

  int mem_wait [2] = '{1, 3};
  int cnt_mod  [2] = '{65536, 4};
  int exp_cnt  [2] = '{0, 0};
  int checks = 0;
  int passed = 0;

  move_special_sequencer #(.MEM_WAIT(1), .CNT_W(16)) dut_a (
    .clk(clk), .clr(clr[0]), .run(run[0]), .IR(ir[0]),
    .PCout(ctl_a[B_PCOUT]), .MARin(ctl_a[B_MARIN]), .IncPC(ctl_a[B_INCPC]), .Zin(ctl_a[B_ZIN]),
    .PCin(ctl_a[B_PCIN]), .Zlowout(ctl_a[B_ZLOWOUT]), .MDRRead(ctl_a[B_MDRREAD]),
    .MDRin(ctl_a[B_MDRIN]), .MDRout(ctl_a[B_MDROUT]), .IRin(ctl_a[B_IRIN]),
    .Gra(ctl_a[B_GRA]), .Rin_in(ctl_a[B_RININ]), .Rout_in(ctl_a[B_ROUTIN]),
    .HIout(ctl_a[B_HIOUT]), .LOout(ctl_a[B_LOOUT]), .HIin(ctl_a[B_HIIN]), .LOin(ctl_a[B_LOIN]),
    .done(ctl_a[B_DONE]), .illegal(ctl_a[B_ILL]), .halted(ctl_a[B_HALTED]),
    .step(stp_a), .instr_count(cnt_a)
  );

  move_special_sequencer #(.MEM_WAIT(3), .CNT_W(2)) dut_b (
    .clk(clk), .clr(clr[1]), .run(run[1]), .IR(ir[1]),
    .PCout(ctl_b[B_PCOUT]), .MARin(ctl_b[B_MARIN]), .IncPC(ctl_b[B_INCPC]), .Zin(ctl_b[B_ZIN]),
    .PCin(ctl_b[B_PCIN]), .Zlowout(ctl_b[B_ZLOWOUT]), .MDRRead(ctl_b[B_MDRREAD]),
    .MDRin(ctl_b[B_MDRIN]), .MDRout(ctl_b[B_MDROUT]), .IRin(ctl_b[B_IRIN]),
    .Gra(ctl_b[B_GRA]), .Rin_in(ctl_b[B_RININ]), .Rout_in(ctl_b[B_ROUTIN]),
    .HIout(ctl_b[B_HIOUT]), .LOout(ctl_b[B_LOOUT]), .HIin(ctl_b[B_HIIN]), .LOin(ctl_b[B_LOIN]),
    .done(ctl_b[B_DONE]), .illegal(ctl_b[B_ILL]), .halted(ctl_b[B_HALTED]),
    .step(stp_b), .instr_count(cnt_b)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Compare controls, step and retired count of one DUT against expectations.
  task automatic check(input int d, input string tag, input logic [NC-1:0] ectl, input logic [2:0] estep);
    logic [NC-1:0] oc;
    logic [2:0]    os;
    int            oct;
    int            ecnt;
    oc   = (d == 0) ? ctl_a : ctl_b;
    os   = (d == 0) ? stp_a : stp_b;
    oct  = (d == 0) ? int'(cnt_a) : int'(cnt_b);
    ecnt = exp_cnt[d] % cnt_mod[d];
    checks++;
    assert (oc === ectl) passed++;
    else $error("FAIL %s dut%0d ctl observed=%b expected=%b", tag, d, oc, ectl);
    checks++;
    assert (os === estep) passed++;
    else $error("FAIL %s dut%0d step observed=%0d expected=%0d", tag, d, os, estep);
    checks++;
    assert (oct === ecnt) passed++;
    else $error("FAIL %s dut%0d count observed=%0d expected=%0d", tag, d, oct, ecnt);
  endtask

  // Walk one instruction from its T0 cycle through T3. The expected cycle list is
  // T0, T1, W memory-wait cycles, T2, T3. IR carries junk until T3, and run may
  // toggle mid-instruction (rand_run) since only its value in T3 matters.
  task automatic exec_instr(input int d, input int opc, input bit run_next, input bit rand_run, input string tag);
    int            w;
    int            n;
    logic [NC-1:0] e;
    logic [2:0]    s;
    logic [31:0]   fin;
    w   = (mem_wait[d] < 1) ? 1 : mem_wait[d];
    n   = 4 + w;
    fin = $urandom;
    fin[31:27] = opc[4:0];
    ir[d] = $urandom;
    for (int i = 0; i < n; i++) begin
      e = '0;
      if (i == 0) begin
        e[B_PCOUT] = 1'b1; e[B_MARIN] = 1'b1; e[B_INCPC] = 1'b1; e[B_ZIN] = 1'b1; s = 3'd1;
      end else if (i == 1) begin
        e[B_ZLOWOUT] = 1'b1; e[B_PCIN] = 1'b1; s = 3'd2;
      end else if (i < 2 + w) begin
        e[B_MDRREAD] = 1'b1;
        if (i == 1 + w) e[B_MDRIN] = 1'b1;
        s = 3'd3;
      end else if (i == 2 + w) begin
        e[B_MDROUT] = 1'b1; e[B_IRIN] = 1'b1; s = 3'd4;
      end else begin
        s = 3'd5;
        e[B_DONE] = 1'b1;
        case (opc)
          25:      begin e[B_GRA] = 1'b1; e[B_RININ]  = 1'b1; e[B_HIOUT] = 1'b1; end
          26:      begin e[B_GRA] = 1'b1; e[B_RININ]  = 1'b1; e[B_LOOUT] = 1'b1; end
          23:      begin e[B_GRA] = 1'b1; e[B_ROUTIN] = 1'b1; e[B_HIIN]  = 1'b1; end
          24:      begin e[B_GRA] = 1'b1; e[B_ROUTIN] = 1'b1; e[B_LOIN]  = 1'b1; end
          27, 28:  ;
          default: e[B_ILL] = 1'b1;
        endcase
      end
      check(d, $sformatf("%s_c%0d", tag, i), e, s);
      if (i == n - 1) begin
        run[d] = run_next;
        exp_cnt[d]++;
      end else begin
        if (rand_run) run[d] = 1'($urandom_range(0, 1));
        if (i == n - 2) ir[d] = fin;
        else            ir[d] = $urandom;
      end
      cyc();
    end
  endtask

  logic [NC-1:0] t0_vec, halt_vec;
  logic [NC-1:0] zero_vec;

  initial begin
    int  opc;
    bit  rn;
    zero_vec = '0;
    t0_vec = '0;
    t0_vec[B_PCOUT] = 1'b1; t0_vec[B_MARIN] = 1'b1; t0_vec[B_INCPC] = 1'b1; t0_vec[B_ZIN] = 1'b1;
    halt_vec = '0;
    halt_vec[B_HALTED] = 1'b1;

    // Reset with run high: clr wins.
    for (int d = 0; d < 2; d++) begin clr[d] = 1'b1; run[d] = 1'b1; ir[d] = '0; end
    cyc();
    for (int d = 0; d < 2; d++) begin clr[d] = 1'b0; run[d] = 1'b0; end
    check(0, "reset", zero_vec, 3'd0);
    check(1, "reset", zero_vec, 3'd0);

    // Fetch + MFHI, MEM_WAIT=1.
    run[0] = 1'b1; cyc();
    exec_instr(0, 25, 1'b0, 1'b0, "mfhi");
    check(0, "mfhi_idle", zero_vec, 3'd0);

    // MEM_WAIT=3 fetch + NOP.
    run[1] = 1'b1; cyc();
    exec_instr(1, 27, 1'b0, 1'b0, "wait3");
    check(1, "wait3_idle", zero_vec, 3'd0);

    // MTLO then MFLO back-to-back.
    run[0] = 1'b1; cyc();
    exec_instr(0, 24, 1'b1, 1'b0, "mtlo");
    exec_instr(0, 26, 1'b0, 1'b0, "mflo");
    check(0, "b2b_idle", zero_vec, 3'd0);

    // Illegal opcode keeps going to T0.
    run[0] = 1'b1; cyc();
    exec_instr(0, 31, 1'b1, 1'b0, "illegal");
    check(0, "illegal_next", t0_vec, 3'd1);
    exec_instr(0, 23, 1'b0, 1'b0, "mthi");
    check(0, "mthi_idle", zero_vec, 3'd0);

    // Randomized instruction streams on both instances.
    for (int d = 0; d < 2; d++) begin
      run[d] = 1'b1; cyc();
      rn = 1'b1;
      for (int k = 0; k < 25; k++) begin
        if ($urandom_range(0, 9) < 6) opc = 23 + $urandom_range(0, 4);
        else begin
          opc = $urandom_range(0, 31);
          if (opc == 28) opc = 0;
        end
        rn = ($urandom_range(0, 3) != 0);
        exec_instr(d, opc, rn, 1'b1, "rnd");
        if (!rn) begin
          check(d, "rnd_idle", zero_vec, 3'd0);
          repeat ($urandom_range(0, 2)) cyc();
          run[d] = 1'b1; cyc();
        end
      end
      exec_instr(d, 27, 1'b0, 1'b0, "rnd_last");
      check(d, "rnd_end", zero_vec, 3'd0);
    end

    // HALT: sticky with run high, cleared only by clr.
    run[0] = 1'b1; cyc();
    exec_instr(0, 28, 1'b1, 1'b0, "halt");
    for (int k = 0; k < 20; k++) begin
      check(0, $sformatf("halted_%0d", k), halt_vec, 3'd6);
      cyc();
    end
    clr[0] = 1'b1; cyc();
    clr[0] = 1'b0; run[0] = 1'b0;
    exp_cnt[0] = 0;
    check(0, "halt_clr", zero_vec, 3'd0);

    // clr during TW abandons the instruction.
    run[1] = 1'b1; cyc();
    check(1, "abort_t0", t0_vec, 3'd1);
    cyc(); cyc();
    check(1, "abort_tw", 20'(1) << B_MDRREAD, 3'd3);
    clr[1] = 1'b1; cyc();
    clr[1] = 1'b0; run[1] = 1'b0;
    exp_cnt[1] = 0;
    check(1, "abort_clr", zero_vec, 3'd0);

    // Five NOPs on the 2-bit counter wrap to 1.
    run[1] = 1'b1; cyc();
    for (int k = 0; k < 5; k++) exec_instr(1, 27, (k != 4), 1'b0, $sformatf("nop%0d", k));
    check(1, "wrap", zero_vec, 3'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/move_special_sequencer.md
# move_special_sequencer

Hardwired control-step sequencer that drives the datapath bus control lines for instruction fetch and the HI/LO special-register move class (mfhi, mflo, mthi, mtlo), plus nop and halt. It replaces hand-driven T0–T3 control sequences with a single-clock FSM. It sits between the IR output and the bus control inputs, with a parametrised memory-wait count and opcode map.

## Interface
- OPC_W, 5: opcode width, taken from IR[31:32-OPC_W]
- MEM_WAIT, 1: cycles MDRRead is held before MDRin is pulsed. Legal range is 1–15; 0 is treated as 1.
- CNT_W, 16: width of the retired-instruction counter
- OP_MTHI, 5'd23; OP_MTLO, 5'd24; OP_MFHI, 5'd25; OP_MFLO, 5'd26; OP_NOP, 5'd27; OP_HALT, 5'd28: opcode map
- clk  in  1  single system clock, rising edge
- clr  in  1  synchronous active-high reset
- run  in  1  level; while high, the sequencer fetches and executes back-to-back instructions
- IR  in  32  current instruction register contents
- PCout, MARin, IncPC, Zin, PCin, Zlowout  out  1 each  fetch controls
- MDRRead, MDRin, MDRout, IRin  out  1 each  memory/IR controls
- Gra, Rin_in, Rout_in  out  1 each  register-select controls
- HIout, LOout, HIin, LOin  out  1 each  special-register controls
- done  out  1  one-cycle pulse on the final execute step
- illegal  out  1  one-cycle pulse in T3 when the opcode is not in the map
- halted  out  1  high while in HALTED
- step  out  3  state encoding, for debug
- instr_count  out  CNT_W  number of retired instructions

## Operation
- States and encodings: IDLE=0, T0=1, T1=2, TW=3, T2=4, T3=5, HALTED=6.
- IDLE: all controls are 0. Transition to T0 when run=1.
- T0: PCout, MARin, IncPC and Zin are 1. Transition to T1.
- T1: Zlowout and PCin are 1. Load the wait counter with max(MEM_WAIT,1)-1, then go to TW.
- TW: MDRRead is 1 on every TW cycle. MDRin is 1 only on the cycle where the counter is 0; on that cycle, transition to T2. Otherwise decrement the counter and stay in TW.
- T2: MDRout and IRin are 1. Transition to T3.
- T3: decode IR[31:32-OPC_W]. IR is already stable because it was latched at the end of T2.
  - MFHI: Gra, Rin_in and HIout are 1.
  - MFLO: Gra, Rin_in and LOout are 1.
  - MTHI: Gra, Rout_in and HIin are 1.
  - MTLO: Gra, Rout_in and LOin are 1.
  - NOP: no datapath controls.
  - HALT: no datapath controls; next state is HALTED.
  - Any other opcode: no datapath controls and illegal=1.
- done=1 in T3 for every opcode, including HALT and illegal.
- instr_count increments by 1 at the end of each T3 cycle and wraps modulo 2^CNT_W. Illegal opcodes count as retired.
- From T3 (not HALT): go to T0 if run=1, else IDLE.
- HALTED: all controls are 0 and halted=1. Leave only via clr; run is ignored.
- Once a fetch starts, run is sampled only in T3 and IDLE. Deasserting run mid-instruction lets the instruction complete.
- At most one bus driver (*out signal) is high in any state.

## Timing
- Reset: on a clk edge with clr=1, the state becomes IDLE and instr_count becomes 0. Every control output, done, illegal and halted is 0 in the cycle after reset. step=0.
- clr overrides run, so a mid-operation reset abandons the instruction. No partial control pulse appears after the reset edge.
- Datapath control outputs are Moore from the state, except in T3, where they also depend on IR. All outputs are registered-state based and change only after clk edges.
- Instruction latency is 4+max(MEM_WAIT,1) cycles from the T0 cycle to the T3 cycle inclusive. With MEM_WAIT=1 this is 5 cycles.
- Back-to-back operation: the T0 of the next instruction immediately follows T3, with no bubble.
- run rising while in IDLE: T0 occurs in the next cycle, giving 1 cycle of latency.

## Test plan
- Fetch plus MFHI (IR=32'hC900_0000, opcode 25), MEM_WAIT=1, run held high for one instruction. Required: step sequence 1,2,3,4,5; Gra, Rin_in and HIout high only in T3; done pulses once; instr_count=1; IDLE after run drops.
- MEM_WAIT=3: MDRRead is high for exactly 3 cycles and MDRin only on the 3rd. The T0-to-T3 span is 7 cycles.
- MTLO (opcode 24, IR=32'hC000_0000) followed by MFLO (opcode 26) with run held. Required: Rout_in and LOin in the first T3; Rin_in and LOout in the second; no idle cycle between them; instr_count=2.
- Illegal opcode 5'd31 in T3: illegal=1 and done=1, all datapath controls 0, instr_count increments, and the sequencer continues to T0.
- HALT (opcode 28): halted=1 from the cycle after T3 and stays high with run=1 for 20 cycles. Asserting clr for 1 cycle returns the block to IDLE with halted=0 and instr_count=0.
- Assert clr during TW with MEM_WAIT=3. Required: next cycle step=0, all outputs 0. With CNT_W=2, five retired nops give instr_count=1.
